// File: rtl/trg_mon_frame_tx_pkg.sv
// Shared definitions for the trigger-monitor telemetry framer: state encodings,
// framing constants and the running-checksum helper.
package trg_mon_frame_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_STORE = 4'd1,
    ST_HDR   = 4'd2,
    ST_FCNT  = 4'd3,
    ST_RD    = 4'd4,
    ST_CAP   = 4'd5,
    ST_DATA  = 4'd6,
    ST_CKS   = 4'd7,
    ST_DONE  = 4'd8
  } tm_state_e;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_HI   = 2'd1,
    WB_GAP  = 2'd2,
    WB_LO   = 2'd3
  } wb_phase_e;

  localparam logic [15:0] TM_SYNC_WORD   = 16'hEB90;
  localparam logic [7:0]  TM_ADDR_FIRST  = 8'h02;
  localparam logic [7:0]  TM_ADDR_LAST   = 8'h24;
  localparam int          TM_DATA_WORDS  = 35;
  localparam int          TM_FRAME_WORDS = 2 + TM_DATA_WORDS + 1;

  // Frame checksum is a plain 16-bit modular sum.
  function automatic logic [15:0] cksum_add(input logic [15:0] acc_s, input logic [15:0] word_s);
    return acc_s + word_s;
  endfunction

endpackage

// File: rtl/trg_mon_frame_tx_word_to_byte.sv
// Serialises one 16-bit word into two bytes (high first) over valid/ready.
// busy_out stays high from the cycle after load until the low byte is accepted.
module tm_word_to_byte
  import trg_mon_frame_tx_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        load_in,
  input  logic [15:0] word_in,
  output logic        busy_out,
  output logic [7:0]  byte_data_out,
  output logic        byte_valid_out,
  input  logic        byte_ready_in
);

  wb_phase_e  phase_r;
  logic [7:0] lo_byte_r;
  logic [7:0] data_r;
  logic       valid_r;

  // Byte phase sequencer; valid is only ever dropped after an accepted byte.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase_r   <= WB_IDLE;
      lo_byte_r <= 8'h00;
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
    end else begin
      case (phase_r)
        WB_IDLE: begin
          if (load_in) begin
            lo_byte_r <= word_in[7:0];
            data_r    <= word_in[15:8];
            valid_r   <= 1'b1;
            phase_r   <= WB_HI;
          end else begin
            phase_r <= WB_IDLE;
          end
        end
        WB_HI: begin
          if (byte_ready_in) begin
            valid_r <= 1'b0;
            phase_r <= WB_GAP;
          end else begin
            phase_r <= WB_HI;
          end
        end
        WB_GAP: begin
          data_r  <= lo_byte_r;
          valid_r <= 1'b1;
          phase_r <= WB_LO;
        end
        WB_LO: begin
          if (byte_ready_in) begin
            valid_r <= 1'b0;
            phase_r <= WB_IDLE;
          end else begin
            phase_r <= WB_LO;
          end
        end
        default: begin
          valid_r <= 1'b0;
          phase_r <= WB_IDLE;
        end
      endcase
    end
  end

  assign busy_out       = (phase_r != WB_IDLE);
  assign byte_data_out  = data_r;
  assign byte_valid_out = valid_r;

endmodule

// File: rtl/trg_mon_frame_tx.sv
// Telemetry framer: snapshots the monitor bank, reads it word by word and streams
// sync, frame count, data words and checksum as bytes to the serializer.
module trg_mon_frame_tx
  import trg_mon_frame_tx_pkg::*;
#(
  parameter logic [7:0]  ADDR_FIRST = TM_ADDR_FIRST,
  parameter logic [7:0]  ADDR_LAST  = TM_ADDR_LAST,
  parameter logic [15:0] SYNC_WORD  = TM_SYNC_WORD
)
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        tm_req_in,
  output logic        store_en_out,
  output logic        rd_out,
  output logic [7:0]  rd_addr_out,
  input  logic [15:0] mon_data_in,
  output logic [7:0]  byte_data_out,
  output logic        byte_valid_out,
  input  logic        byte_ready_in,
  output logic        tm_busy_out,
  output logic        frame_done_out,
  output logic [15:0] frame_cnt_out,
  output logic [7:0]  req_drop_cnt_out
);

  tm_state_e   state_r;
  tm_state_e   state_s;
  tm_state_e   send_next_s;
  logic        load_s;
  logic        loaded_r;
  logic        w2b_busy_s;
  logic [15:0] word_s;
  logic [15:0] fcnt_snap_r;
  logic [15:0] mon_word_r;
  logic [15:0] cksum_r;
  logic [7:0]  rd_addr_r;
  logic        store_en_r;
  logic        rd_r;
  logic        busy_r;
  logic        done_r;
  logic [15:0] frame_cnt_r;
  logic [7:0]  drop_cnt_r;

  // State register; loaded_r marks that the current send state has handed its word over.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r  <= ST_IDLE;
      loaded_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r) begin
        loaded_r <= 1'b0;
      end else if (load_s) begin
        loaded_r <= 1'b1;
      end else begin
        loaded_r <= loaded_r;
      end
    end
  end

  // Successor of each word-send state once its word has left the serializer.
  always_comb begin
    send_next_s = ST_IDLE;
    case (state_r)
      ST_HDR:  send_next_s = ST_FCNT;
      ST_FCNT: send_next_s = ST_RD;
      ST_DATA: send_next_s = (rd_addr_r == ADDR_LAST) ? ST_CKS : ST_RD;
      ST_CKS:  send_next_s = ST_DONE;
      default: send_next_s = ST_IDLE;
    endcase
  end

  // Next-state logic and serializer load request.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tm_req_in) begin
          state_s = ST_STORE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STORE: state_s = ST_HDR;
      ST_HDR, ST_FCNT, ST_DATA, ST_CKS: begin
        if (!loaded_r) begin
          load_s = 1'b1;
        end else if (!w2b_busy_s) begin
          state_s = send_next_s;
        end else begin
          state_s = state_r;
        end
      end
      ST_RD:   state_s = ST_CAP;
      ST_CAP:  state_s = ST_DATA;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Word presented to the serializer in each send state.
  always_comb begin
    word_s = 16'h0000;
    case (state_r)
      ST_HDR:  word_s = SYNC_WORD;
      ST_FCNT: word_s = fcnt_snap_r;
      ST_DATA: word_s = mon_word_r;
      ST_CKS:  word_s = cksum_r;
      default: word_s = 16'h0000;
    endcase
  end

  // Strobes are registered from the next state so they align exactly with their state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      store_en_r <= 1'b0;
      rd_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      store_en_r <= (state_s == ST_STORE);
      rd_r       <= (state_s == ST_RD);
      busy_r     <= (state_s != ST_IDLE) && (state_s != ST_DONE);
      done_r     <= (state_s == ST_DONE);
    end
  end

  // Frame datapath: read address, captured word and running checksum.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fcnt_snap_r <= 16'h0000;
      mon_word_r  <= 16'h0000;
      cksum_r     <= 16'h0000;
      rd_addr_r   <= 8'h00;
    end else begin
      if ((state_r == ST_IDLE) && tm_req_in) begin
        fcnt_snap_r <= frame_cnt_r;
      end else begin
        fcnt_snap_r <= fcnt_snap_r;
      end
      case (state_r)
        ST_STORE: begin
          rd_addr_r <= ADDR_FIRST;
          cksum_r   <= 16'h0000;
        end
        ST_FCNT: begin
          if (load_s) begin
            cksum_r <= cksum_add(cksum_r, fcnt_snap_r);
          end else begin
            cksum_r <= cksum_r;
          end
        end
        ST_CAP: begin
          mon_word_r <= mon_data_in;
          cksum_r    <= cksum_add(cksum_r, mon_data_in);
        end
        ST_DATA: begin
          if (state_s == ST_RD) begin
            rd_addr_r <= rd_addr_r + 8'd1;
          end else begin
            rd_addr_r <= rd_addr_r;
          end
        end
        default: begin
          rd_addr_r <= rd_addr_r;
        end
      endcase
    end
  end

  // Completed-frame counter (wraps) and dropped-request counter (saturates).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_cnt_r <= 16'h0000;
      drop_cnt_r  <= 8'h00;
    end else begin
      if ((state_r == ST_CKS) && (state_s == ST_DONE)) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      if (tm_req_in && (state_r != ST_IDLE) && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  tm_word_to_byte u_w2b (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .load_in        (load_s),
    .word_in        (word_s),
    .busy_out       (w2b_busy_s),
    .byte_data_out  (byte_data_out),
    .byte_valid_out (byte_valid_out),
    .byte_ready_in  (byte_ready_in)
  );

  assign store_en_out     = store_en_r;
  assign rd_out           = rd_r;
  assign rd_addr_out      = rd_addr_r;
  assign tm_busy_out      = busy_r;
  assign frame_done_out   = done_r;
  assign frame_cnt_out    = frame_cnt_r;
  assign req_drop_cnt_out = drop_cnt_r;

endmodule

// File: tb/tb_trg_mon_frame_tx.sv
// Randomized self-checking bench for trg_mon_frame_tx: a bank model feeds read data,
// a frame-level reference builds the expected byte stream from sync/count/data/checksum.
module tb_trg_mon_frame_tx;

  localparam int N_WORDS   = 35;
  localparam int N_BYTES   = 76;
  localparam int ADDR_BASE = 2;

  logic        clk_in;
  logic        rst_n_in;
  logic        tm_req_in;
  logic        store_en_out;
  logic        rd_out;
  logic [7:0]  rd_addr_out;
  logic [15:0] mon_data_in;
  logic [7:0]  byte_data_out;
  logic        byte_valid_out;
  logic        byte_ready_in;
  logic        tm_busy_out;
  logic        frame_done_out;
  logic [15:0] frame_cnt_out;
  logic [7:0]  req_drop_cnt_out;

  trg_mon_frame_tx dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .tm_req_in        (tm_req_in),
    .store_en_out     (store_en_out),
    .rd_out           (rd_out),
    .rd_addr_out      (rd_addr_out),
    .mon_data_in      (mon_data_in),
    .byte_data_out    (byte_data_out),
    .byte_valid_out   (byte_valid_out),
    .byte_ready_in    (byte_ready_in),
    .tm_busy_out      (tm_busy_out),
    .frame_done_out   (frame_done_out),
    .frame_cnt_out    (frame_cnt_out),
    .req_drop_cnt_out (req_drop_cnt_out)
  );

  int          err_cnt   = 0;
  int          chk_cnt   = 0;
  int          cyc       = 0;
  int          ready_mode = 0;
  logic [15:0] fw [0:N_WORDS-1];
  logic [7:0]  cap_q [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  rd_q [$];
  int          store_cnt, done_cnt, store_cyc, first_rd_cyc, req_cyc;
  logic        busy_at_store;
  logic [15:0] exp_fcnt = 16'h0000;
  logic [7:0]  exp_drop = 8'h00;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    clk_in = 1'b0;
    forever #10 clk_in = ~clk_in;
  end

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  // Bank model: data is driven only during the cycle after rd_out, garbage otherwise.
  initial begin : bank
    logic        pend_v;
    logic [15:0] pend_d;
    int          a;
    pend_v = 1'b0;
    pend_d = 16'h0000;
    forever begin
      @(posedge clk_in);
      #1;
      mon_data_in = pend_v ? pend_d : 16'hDEAD;
      if (rd_out) begin
        a = int'(rd_addr_out) - ADDR_BASE;
        pend_d = (a >= 0 && a < N_WORDS) ? fw[a] : 16'hBAD0;
        pend_v = 1'b1;
      end else begin
        pend_v = 1'b0;
      end
    end
  end

  // Monitor and ready driver, working on the falling edge.
  initial begin : mon
    logic       prev_valid, prev_ready;
    logic [7:0] prev_data;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
      end else begin
        if (prev_valid && !prev_ready) begin
          chk("stall_valid", byte_valid_out, 1'b1);
          chk("stall_data", byte_data_out, prev_data);
        end
        if (store_en_out) begin
          store_cnt++;
          store_cyc     = cyc;
          busy_at_store = tm_busy_out;
        end
        if (rd_out) begin
          if (rd_q.size() == 0) first_rd_cyc = cyc;
          rd_q.push_back(rd_addr_out);
        end
        if (frame_done_out) done_cnt++;
        case (ready_mode)
          0:       byte_ready_in = 1'b1;
          1:       byte_ready_in = ($urandom_range(0, 99) >= 30);
          default: byte_ready_in = 1'b0;
        endcase
        if (byte_valid_out && byte_ready_in) cap_q.push_back(byte_data_out);
        prev_valid = byte_valid_out;
        prev_ready = byte_ready_in;
        prev_data  = byte_data_out;
      end
    end
  end

  task automatic fill_words(input int mode);
    for (int i = 0; i < N_WORDS; i++) begin
      case (mode)
        0:       fw[i] = {8'hA0, 8'(ADDR_BASE + i)};
        1:       fw[i] = 16'hFFFF;
        default: fw[i] = 16'($urandom_range(0, 65535));
      endcase
    end
  endtask

  // Reference frame built from the framing rules with plain arithmetic.
  task automatic build_expected();
    logic [31:0] sum;
    logic [15:0] w;
    exp_q.delete();
    sum = {16'h0000, exp_fcnt};
    exp_q.push_back(8'hEB);
    exp_q.push_back(8'h90);
    exp_q.push_back(exp_fcnt[15:8]);
    exp_q.push_back(exp_fcnt[7:0]);
    for (int i = 0; i < N_WORDS; i++) begin
      w = fw[i];
      sum = sum + {16'h0000, w};
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    w = 16'(sum % 32'd65536);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic start_req();
    @(negedge clk_in);
    tm_req_in = 1'b1;
    req_cyc   = cyc;
    @(negedge clk_in);
    tm_req_in = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (done_cnt == 0 && t < 20000) begin
      @(negedge clk_in);
      t++;
    end
    chk({tag, "_timeout"}, (done_cnt != 0), 1'b1);
    repeat (3) @(negedge clk_in);
  endtask

  task automatic run_frame(input string tag, input int n_drops);
    int n;
    build_expected();
    cap_q.delete();
    rd_q.delete();
    store_cnt = 0;
    done_cnt  = 0;
    store_cyc = -1;
    first_rd_cyc = -1;
    start_req();
    for (int d = 0; d < n_drops; d++) begin
      repeat (15) @(negedge clk_in);
      tm_req_in = 1'b1;
      @(negedge clk_in);
      tm_req_in = 1'b0;
      if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
    end
    wait_done(tag);
    exp_fcnt = exp_fcnt + 16'd1;
    chk({tag, "_nbytes"}, cap_q.size(), N_BYTES);
    n = (cap_q.size() < N_BYTES) ? cap_q.size() : N_BYTES;
    for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), cap_q[i], exp_q[i]);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_store_pulses"}, store_cnt, 1);
    chk({tag, "_store_cycle"}, store_cyc, req_cyc + 1);
    chk({tag, "_busy_at_store"}, busy_at_store, 1'b1);
    chk({tag, "_rd_after_store"}, (first_rd_cyc > store_cyc), 1'b1);
    chk({tag, "_nreads"}, rd_q.size(), N_WORDS);
    for (int i = 0; i < rd_q.size() && i < N_WORDS; i++)
      chk($sformatf("%s_rdaddr%0d", tag, i), rd_q[i], ADDR_BASE + i);
    chk({tag, "_frame_cnt"}, frame_cnt_out, exp_fcnt);
    chk({tag, "_drop_cnt"}, req_drop_cnt_out, exp_drop);
    chk({tag, "_busy_end"}, tm_busy_out, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_store_en"}, store_en_out, 1'b0);
    chk({tag, "_rd"}, rd_out, 1'b0);
    chk({tag, "_rd_addr"}, rd_addr_out, 8'h00);
    chk({tag, "_byte_data"}, byte_data_out, 8'h00);
    chk({tag, "_byte_valid"}, byte_valid_out, 1'b0);
    chk({tag, "_busy"}, tm_busy_out, 1'b0);
    chk({tag, "_done"}, frame_done_out, 1'b0);
    chk({tag, "_frame_cnt"}, frame_cnt_out, 16'h0000);
    chk({tag, "_drop_cnt"}, req_drop_cnt_out, 8'h00);
  endtask

  initial begin : main
    int t;
    rst_n_in      = 1'b0;
    tm_req_in     = 1'b0;
    mon_data_in   = 16'h0000;
    byte_ready_in = 1'b0;
    fill_words(0);
    repeat (3) @(negedge clk_in);
    chk_all_zero("reset");
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);

    ready_mode = 0;
    run_frame("basic", 0);
    ready_mode = 1;
    run_frame("stall", 0);
    fill_words(2);
    run_frame("rand_data", 0);

    ready_mode = 0;
    fill_words(0);
    run_frame("drops", 3);

    // Saturate the drop counter while the serializer is held off.
    ready_mode = 2;
    done_cnt   = 0;
    @(negedge clk_in);
    tm_req_in = 1'b1;
    repeat (301) @(negedge clk_in);
    tm_req_in = 1'b0;
    exp_drop  = 8'hFF;
    chk("sat_drop_cnt", req_drop_cnt_out, 8'hFF);
    chk("sat_busy", tm_busy_out, 1'b1);
    ready_mode = 0;
    wait_done("sat");
    exp_fcnt = exp_fcnt + 16'd1;
    chk("sat_frame_cnt", frame_cnt_out, exp_fcnt);

    // Abort a frame by reset after byte 20.
    cap_q.delete();
    done_cnt = 0;
    start_req();
    t = 0;
    while (cap_q.size() < 20 && t < 5000) begin
      @(negedge clk_in);
      t++;
    end
    chk("abort_reach20", (cap_q.size() >= 20), 1'b1);
    #2 rst_n_in = 1'b0;
    #1 chk_all_zero("abort");
    chk("abort_no_done", done_cnt, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    exp_fcnt = 16'h0000;
    exp_drop = 8'h00;
    repeat (2) @(negedge clk_in);
    run_frame("after_abort", 0);

    // Frame count wrap with all-ones data for checksum wrap.
    @(negedge clk_in);
    dut.frame_cnt_r = 16'hFFFF;
    exp_fcnt = 16'hFFFF;
    fill_words(1);
    ready_mode = 1;
    run_frame("wrap", 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
